// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Merges the instruction-fetch port (i_mem_*) and the LSQ port (lsq_mem_*) onto a single
//   physical-memory port. Only one transaction is outstanding at a time, and a registered grant
//   FSM (IDLE, I_BUSY, D_BUSY, DRAIN) arbitrates between the two clients. Fetches return two
//   words and loads return the low word. Stores place their data and byte mask in the low half
//   of the wide memory port.
//
// Configuration
//   MEM_ARB_RR_EN : when defined, a 1-bit last-granted register alternates grants on a
//                   simultaneous fetch+LSQ request. When undefined, the LSQ has fixed priority.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   i_mem_read            fetch request, held until i_mem_resp
//   i_mem_address         fetch address (word aligned)
//   i_mem_resp            1-cycle fetch completion pulse
//   i_mem_rdata           {word@addr+4, word@addr}
//   lsq_mem_read/_write   LSQ load/store request, held until lsq_mem_resp (never both)
//   lsq_mem_address       LSQ address
//   lsq_mem_wdata         store data
//   lsq_mem_byte_enable   store byte mask
//   lsq_mem_resp          1-cycle LSQ completion pulse
//   lsq_mem_rdata         load data (low word of mem_rdata)
//   mem_read/mem_write    registered memory strobes, held until mem_resp
//   mem_address           registered memory address
//   mem_wdata             {0, store data}
//   mem_byte_enable       {0, store byte mask}; 0 for reads
//   mem_resp              memory completion pulse
//   mem_rdata             {word@addr+4, word@addr}

module mem_arbiter #(
    parameter int unsigned width = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_mem_read,
    input  logic [width-1:0]     i_mem_address,
    output logic                 i_mem_resp,
    output logic [2*width-1:0]   i_mem_rdata,

    input  logic                 lsq_mem_read,
    input  logic                 lsq_mem_write,
    input  logic [width-1:0]     lsq_mem_address,
    input  logic [width-1:0]     lsq_mem_wdata,
    input  logic [width/8-1:0]   lsq_mem_byte_enable,
    output logic                 lsq_mem_resp,
    output logic [width-1:0]     lsq_mem_rdata,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [width-1:0]     mem_address,
    output logic [2*width-1:0]   mem_wdata,
    output logic [width/4-1:0]   mem_byte_enable,
    input  logic                 mem_resp,
    input  logic [2*width-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StIBusy,
        StDBusy,
        StDrain
    } state_e;

    state_e               state_q;
    logic [width-1:0]     addr_q;
    logic [width-1:0]     wdata_q;
    logic [width/8-1:0]   be_q;
    logic                 read_q;
    logic                 write_q;

    logic fetch_req;
    logic lsq_req;
    logic lsq_wins;
    logic grant_lsq;
    logic grant_fetch;

    assign fetch_req = i_mem_read;
    assign lsq_req   = lsq_mem_read | lsq_mem_write;

    // Grant decisions are only taken in IDLE; lsq_wins resolves a same-cycle collision.
    assign grant_lsq   = (state_q == StIdle) && lsq_req && (!fetch_req || lsq_wins);
    assign grant_fetch = (state_q == StIdle) && fetch_req && !grant_lsq;

`ifdef MEM_ARB_RR_EN
    // 1 = fetch was granted last; reset state favours the LSQ on the first collision.
    logic last_fetch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_fetch_q <= 1'b1;
        end else if (grant_lsq) begin
            last_fetch_q <= 1'b0;
        end else if (grant_fetch) begin
            last_fetch_q <= 1'b1;
        end
    end

    assign lsq_wins = last_fetch_q;
`else
    assign lsq_wins = 1'b1;
`endif

    // Grant FSM. Memory strobes and request fields come only from these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // mem_resp arriving here belongs to no live transaction and is ignored.
                    if (grant_lsq) begin
                        state_q <= StDBusy;
                        addr_q  <= lsq_mem_address;
                        wdata_q <= lsq_mem_wdata;
                        be_q    <= lsq_mem_write ? lsq_mem_byte_enable : '0;
                        read_q  <= lsq_mem_read;
                        write_q <= lsq_mem_write;
                    end else if (grant_fetch) begin
                        state_q <= StIBusy;
                        addr_q  <= i_mem_address;
                        wdata_q <= '0;
                        be_q    <= '0;
                        read_q  <= 1'b1;
                        write_q <= 1'b0;
                    end
                end
                StIBusy: begin
                    if (mem_resp) begin
                        state_q <= StIdle;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end else if (!fetch_req) begin
                        // Fetch withdrawn (flush): let memory finish, but swallow the response.
                        state_q <= StDrain;
                    end
                end
                StDBusy: begin
                    if (mem_resp) begin
                        state_q <= StIdle;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end else if (!lsq_req) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (mem_resp) begin
                        state_q <= StIdle;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read        = read_q;
    assign mem_write       = write_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = {{width{1'b0}}, wdata_q};
    assign mem_byte_enable = {{(width/8){1'b0}}, be_q};

    // Completion is passed straight through in the mem_resp cycle; a client that has
    // already dropped its request never sees a response.
    assign i_mem_resp    = (state_q == StIBusy) && mem_resp && fetch_req;
    assign lsq_mem_resp  = (state_q == StDBusy) && mem_resp && lsq_req;
    assign i_mem_rdata   = mem_rdata;
    assign lsq_mem_rdata = mem_rdata[width-1:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A memory model answers each transaction after a
// per-transaction latency. Every transaction is described in a scoreboard queue when its
// request is raised, and is popped and compared when it appears on the memory port.
// Clients drop their request in the cycle after their response.

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_read;
    logic [31:0] i_mem_address;
    logic        i_mem_resp;
    logic [63:0] i_mem_rdata;
    logic        lsq_mem_read;
    logic        lsq_mem_write;
    logic [31:0] lsq_mem_address;
    logic [31:0] lsq_mem_wdata;
    logic [3:0]  lsq_mem_byte_enable;
    logic        lsq_mem_resp;
    logic [31:0] lsq_mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_byte_enable;
    logic        mem_resp;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.width(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_mem_read          (i_mem_read),
        .i_mem_address       (i_mem_address),
        .i_mem_resp          (i_mem_resp),
        .i_mem_rdata         (i_mem_rdata),
        .lsq_mem_read        (lsq_mem_read),
        .lsq_mem_write       (lsq_mem_write),
        .lsq_mem_address     (lsq_mem_address),
        .lsq_mem_wdata       (lsq_mem_wdata),
        .lsq_mem_byte_enable (lsq_mem_byte_enable),
        .lsq_mem_resp        (lsq_mem_resp),
        .lsq_mem_rdata       (lsq_mem_rdata),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .mem_address         (mem_address),
        .mem_wdata           (mem_wdata),
        .mem_byte_enable     (mem_byte_enable),
        .mem_resp            (mem_resp),
        .mem_rdata           (mem_rdata)
    );

    typedef struct {
        logic        is_fetch;
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [63:0] rdata;
        logic        resp_exp;  // client should see a response
        int          lat;
        logic        b2b;       // already pending when the previous transaction completed
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic active;
    int   cnt;
    int   tick_no;
    int   last_resp_tick;
    logic done_fetch;
    logic done_lsq;
    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] rd_of(input logic [31:0] a);
        return {a ^ 32'hA5A5_0004, a ^ 32'h5A5A_0000};
    endfunction

    function automatic exp_t mk(input logic f, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be,
                                input logic [63:0] rd, input logic re, input int lat,
                                input logic b2b);
        exp_t e;
        e.is_fetch = f;
        e.is_write = w;
        e.addr     = a;
        e.wdata    = wd;
        e.be       = be;
        e.rdata    = rd;
        e.resp_exp = re;
        e.lat      = lat;
        e.b2b      = b2b;
        return e;
    endfunction

    task automatic raise_fetch(input logic [31:0] a);
        i_mem_read    = 1'b1;
        i_mem_address = a;
    endtask

    task automatic raise_load(input logic [31:0] a);
        lsq_mem_read        = 1'b1;
        lsq_mem_write       = 1'b0;
        lsq_mem_address     = a;
        lsq_mem_wdata       = 32'h0;
        lsq_mem_byte_enable = 4'h0;
    endtask

    // One clock: memory model + client response handling + scoreboard checks.
    task automatic tick();
        logic resp_now;
        @(negedge clk);
        tick_no++;
        resp_now = 1'b0;
        if (mem_resp) begin
            mem_resp = 1'b0;
            if (active) begin
                active = 1'b0;
                if (cur.is_fetch) begin
                    i_mem_read = 1'b0;
                    done_fetch = 1'b1;
                end else begin
                    lsq_mem_read  = 1'b0;
                    lsq_mem_write = 1'b0;
                    done_lsq      = 1'b1;
                end
            end
        end else if (active && cnt == 0) begin
            mem_rdata      = cur.rdata;
            mem_resp       = 1'b1;
            resp_now       = 1'b1;
            last_resp_tick = tick_no;
        end
        #1;
        if (resp_now) begin
            check("i_mem_resp", 64'(i_mem_resp), 64'(cur.is_fetch & cur.resp_exp));
            check("lsq_mem_resp", 64'(lsq_mem_resp), 64'(!cur.is_fetch & cur.resp_exp));
            if (cur.is_fetch) check("i_mem_rdata", i_mem_rdata, cur.rdata);
            else check("lsq_mem_rdata", 64'(lsq_mem_rdata), 64'(cur.rdata[31:0]));
        end else begin
            check("no_resp", 64'({i_mem_resp, lsq_mem_resp}), 64'(2'b00));
            if (active) begin
                check("hold_addr", 64'(mem_address), 64'(cur.addr));
                check("hold_op", 64'({mem_read, mem_write}), 64'({!cur.is_write, cur.is_write}));
                cnt--;
            end else if (mem_read || mem_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_txn", 64'({mem_read, mem_write}), 64'(2'b00));
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    cnt    = cur.lat;
                    check("mem_address", 64'(mem_address), 64'(cur.addr));
                    check("mem_op", 64'({mem_read, mem_write}),
                          64'({!cur.is_write, cur.is_write}));
                    check("mem_byte_enable", 64'(mem_byte_enable),
                          64'(cur.is_write ? {4'h0, cur.be} : 8'h00));
                    if (cur.is_write) check("mem_wdata", mem_wdata, {32'h0, cur.wdata});
                    if (cur.b2b) check("grant_gap", 64'(tick_no - last_resp_tick), 64'd2);
                end
            end
        end
    endtask

    task automatic wait_fetch(input string tag, input int budget);
        done_fetch = 1'b0;
        for (int i = 0; i < budget && !done_fetch; i++) tick();
        check(tag, 64'(done_fetch), 64'd1);
    endtask

    task automatic wait_lsq(input string tag, input int budget);
        done_lsq = 1'b0;
        for (int i = 0; i < budget && !done_lsq; i++) tick();
        check(tag, 64'(done_lsq), 64'd1);
    endtask

    task automatic apply_reset();
        rst                 = 1'b1;
        i_mem_read          = 1'b0;
        i_mem_address       = 32'h0;
        lsq_mem_read        = 1'b0;
        lsq_mem_write       = 1'b0;
        lsq_mem_address     = 32'h0;
        lsq_mem_wdata       = 32'h0;
        lsq_mem_byte_enable = 4'h0;
        mem_resp            = 1'b0;
        active              = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        tick_no        = 0;
        last_resp_tick = -100;
        mem_rdata      = 64'h0;
        done_fetch     = 1'b0;
        done_lsq       = 1'b0;
        apply_reset();

        // Reset state
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_mem_be", 64'(mem_byte_enable), 64'd0);
        check("rst_resps", 64'({i_mem_resp, lsq_mem_resp}), 64'd0);

        // 1: lone fetch
        exp_q.push_back(mk(1'b1, 1'b0, 32'h60, 32'h0, 4'h0, 64'h11112222_33334444, 1'b1, 3, 1'b0));
        raise_fetch(32'h60);
        tick();
        check("t1_mem_read_n1", 64'(mem_read), 64'd1);
        wait_fetch("t1_done", 20);

        // 2: store
        exp_q.push_back(mk(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, rd_of(32'h100), 1'b1,
                           2, 1'b0));
        lsq_mem_write       = 1'b1;
        lsq_mem_address     = 32'h100;
        lsq_mem_wdata       = 32'hDEADBEEF;
        lsq_mem_byte_enable = 4'b0011;
        wait_lsq("t2_done", 20);

`ifndef MEM_ARB_RR_EN
        // 3: fixed priority, LSQ wins two collisions in a row
        exp_q.push_back(mk(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, rd_of(32'h300), 1'b1, 2, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd_of(32'h40), 1'b1, 2, 1'b1));
        raise_load(32'h300);
        raise_fetch(32'h40);
        wait_lsq("t3_load1", 20);
        exp_q.push_front(mk(1'b0, 1'b0, 32'h304, 32'h0, 4'h0, rd_of(32'h304), 1'b1, 2, 1'b1));
        raise_load(32'h304);
        wait_lsq("t3_load2", 20);
        wait_fetch("t3_fetch", 20);
`else
        // 4: round robin from reset, D,I,D,I,D,I
        apply_reset();
        begin
            int nl;
            int nf;
            nl = 1;
            nf = 1;
            exp_q.push_back(mk(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, rd_of(32'h300), 1'b1, 1, 1'b0));
            exp_q.push_back(mk(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd_of(32'h40), 1'b1, 1, 1'b1));
            raise_load(32'h300);
            raise_fetch(32'h40);
            for (int i = 0; i < 200 && (exp_q.size() != 0 || active || mem_resp); i++) begin
                done_fetch = 1'b0;
                done_lsq   = 1'b0;
                tick();
                if (done_lsq && nl < 3) begin
                    exp_q.push_back(mk(1'b0, 1'b0, 32'h300 + 32'(4 * nl), 32'h0, 4'h0,
                                       rd_of(32'h300 + 32'(4 * nl)), 1'b1, 1, 1'b1));
                    raise_load(32'h300 + 32'(4 * nl));
                    nl++;
                end
                if (done_fetch && nf < 3) begin
                    exp_q.push_back(mk(1'b1, 1'b0, 32'h40 + 32'(8 * nf), 32'h0, 4'h0,
                                       rd_of(32'h40 + 32'(8 * nf)), 1'b1, 1, 1'b1));
                    raise_fetch(32'h40 + 32'(8 * nf));
                    nf++;
                end
            end
            check("t4_drained", 64'(exp_q.size() == 0 && !active), 64'd1);
            check("t4_loads", 64'(nl), 64'd3);
            check("t4_fetches", 64'(nf), 64'd3);
        end
`endif

        // 5: fetch withdrawn while granted, pending load waits for the drain
        tick();
        exp_q.push_back(mk(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, rd_of(32'h80), 1'b0, 5, 1'b0));
        raise_fetch(32'h80);
        tick();
        tick();
        i_mem_read = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, rd_of(32'h400), 1'b1, 2, 1'b1));
        raise_load(32'h400);
        wait_lsq("t5_load", 30);

        // 6: reset during D_BUSY, then a late mem_resp
        tick();
        exp_q.push_back(mk(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, rd_of(32'h500), 1'b1, 20, 1'b0));
        raise_load(32'h500);
        tick();
        tick();
        check("t6_busy", 64'(mem_read), 64'd1);
        rst          = 1'b1;
        lsq_mem_read = 1'b0;
        active       = 1'b0;
        exp_q.delete();
        tick();
        check("t6_rst_read", 64'(mem_read), 64'd0);
        check("t6_rst_write", 64'(mem_write), 64'd0);
        rst       = 1'b0;
        mem_rdata = rd_of(32'h500);
        mem_resp  = 1'b1;
        #1;
        check("t6_late_resp", 64'({i_mem_resp, lsq_mem_resp}), 64'd0);
        tick();
        tick();
        tick();
        check("t6_no_txn", 64'({mem_read, mem_write}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
